// File: rtl/ball_motion_ctrl.sv
// Per-frame ball game state: motion, edge bounce, camera hit detection, score.
// Optional BALL_SPEEDUP_EN: each accepted hit raises both step sizes up to MAX_SPEED.
module ball_motion_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BALL_SIZE       = 20,
  parameter int SPEED_X         = 2,
  parameter int SPEED_Y         = 2,
  parameter int MAX_SPEED       = 8,
  parameter int HIT_THRESHOLD   = 16,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       is_hit_area,
  input  logic       hit_pixel,
  input  logic       game_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [6:0] score,
  output logic       game_over,
  output logic       hit_pulse
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  X_HOME = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  V_END  = 10'(V_ACTIVE);

  // Speed registers must hold the largest of base and cap values.
  localparam int SPD_TOP = (MAX_SPEED > SPEED_X) ? ((MAX_SPEED > SPEED_Y) ? MAX_SPEED : SPEED_Y)
                                                 : ((SPEED_X > SPEED_Y) ? SPEED_X : SPEED_Y);
  localparam int SPD_W   = $clog2(SPD_TOP + 1);

  logic [1:0]       state_q, state_d;
  logic [9:0]       y_prev_q, y_prev_d;
  logic [7:0]       hit_cnt_q, hit_cnt_d;
  logic [7:0]       cool_q, cool_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dir_x_q, dir_x_d;   // 1 = right
  logic             dir_y_q, dir_y_d;   // 1 = down
  logic [6:0]       score_q, score_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic [SPD_W-1:0] spd_x, spd_y;

  logic        frame_end, hit_px, frame_hit, take_hit, dir_y_n;
  logic [10:0] x_sum, x_dif, y_sum, y_dif;

`ifdef BALL_SPEEDUP_EN
  logic [SPD_W-1:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
  assign spd_x = spd_x_q;
  assign spd_y = spd_y_q;
`else
  assign spd_x = SPD_W'(SPEED_X);
  assign spd_y = SPD_W'(SPEED_Y);
`endif

  assign frame_end = (y_pixel == V_END) && (y_prev_q != V_END);
  assign hit_px    = is_hit_area && hit_pixel &&
                     (int'(x_pixel) < H_ACTIVE) && (int'(y_pixel) < V_ACTIVE);
  assign frame_hit = int'(hit_cnt_q) >= HIT_THRESHOLD;

  assign x_sum = {1'b0, ball_x_q} + 11'(spd_x);
  assign x_dif = {1'b0, ball_x_q} - 11'(spd_x);
  assign y_sum = {1'b0, ball_y_q} + 11'(spd_y);
  assign y_dif = {1'b0, ball_y_q} - 11'(spd_y);

  always_comb begin
    y_prev_d = y_pixel;
    if (frame_end)
      hit_cnt_d = 8'd0;
    else if (hit_px && hit_cnt_q != 8'hff)
      hit_cnt_d = hit_cnt_q + 8'd1;
    else
      hit_cnt_d = hit_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    cool_d      = cool_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_d     = score_q;
    hit_pulse_d = 1'b0;
    take_hit    = 1'b0;
    dir_y_n     = dir_y_q;
`ifdef BALL_SPEEDUP_EN
    spd_x_d     = spd_x_q;
    spd_y_d     = spd_y_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        // Start beats a coincident frame_end: no step this frame.
        if (game_start) begin
          state_d  = S_PLAY;
          cool_d   = 8'd0;
          ball_x_d = X_HOME;
          ball_y_d = 10'd0;
          dir_x_d  = 1'b1;
          dir_y_d  = 1'b1;
          score_d  = 7'd0;
`ifdef BALL_SPEEDUP_EN
          spd_x_d  = SPD_W'(SPEED_X);
          spd_y_d  = SPD_W'(SPEED_Y);
`endif
        end
      end
      default: begin
        if (frame_end) begin
          take_hit = (state_q == S_PLAY) && frame_hit;
          if (take_hit) begin
            dir_y_n     = 1'b0;
            score_d     = (score_q == 7'd99) ? 7'd99 : score_q + 7'd1;
            hit_pulse_d = 1'b1;
            cool_d      = 8'(COOLDOWN_FRAMES);
            state_d     = S_COOL;
`ifdef BALL_SPEEDUP_EN
            if (int'(spd_x_q) < MAX_SPEED) spd_x_d = spd_x_q + SPD_W'(1);
            if (int'(spd_y_q) < MAX_SPEED) spd_y_d = spd_y_q + SPD_W'(1);
`endif
          end else if (state_q == S_COOL) begin
            if (cool_q <= 8'd1) begin
              cool_d  = 8'd0;
              state_d = S_PLAY;
            end else begin
              cool_d  = cool_q - 8'd1;
            end
          end
          dir_y_d = dir_y_n;

          if (dir_x_q) begin
            if (x_sum >= X_MAX) begin
              ball_x_d = X_MAX[9:0];
              dir_x_d  = 1'b0;
            end else begin
              ball_x_d = x_sum[9:0];
            end
          end else begin
            if ({1'b0, ball_x_q} < 11'(spd_x)) begin
              ball_x_d = 10'd0;
              dir_x_d  = 1'b1;
            end else begin
              ball_x_d = x_dif[9:0];
            end
          end

          // A hit has already turned the ball upward, so it cannot also miss.
          if (!dir_y_n) begin
            if ({1'b0, ball_y_q} < 11'(spd_y)) begin
              ball_y_d = 10'd0;
              dir_y_d  = 1'b1;
            end else begin
              ball_y_d = y_dif[9:0];
            end
          end else begin
            if (y_sum >= Y_MAX) begin
              ball_y_d = Y_MAX[9:0];
              state_d  = S_OVER;
            end else begin
              ball_y_d = y_sum[9:0];
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      y_prev_q    <= 10'd0;
      hit_cnt_q   <= 8'd0;
      cool_q      <= 8'd0;
      ball_x_q    <= X_HOME;
      ball_y_q    <= 10'd0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_q     <= 7'd0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_prev_q    <= y_prev_d;
      hit_cnt_q   <= hit_cnt_d;
      cool_q      <= cool_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_q     <= score_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spd_x_q <= SPD_W'(SPEED_X);
      spd_y_q <= SPD_W'(SPEED_Y);
    end else begin
      spd_x_q <= spd_x_d;
      spd_y_q <= spd_y_d;
    end
  end
`endif

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score     = score_q;
  assign game_over = (state_q == S_OVER);
  assign hit_pulse = hit_pulse_q;

endmodule
